// File: rtl/sub_writeback.sv
// sub_writeback: tracks subtracts issued to the external subtracter, samples
// the registered difference one cycle after issue, derives {V,C,N,Z} and
// queues {result, tag, flags} in a small FIFO that drains over valid/ready.
module sub_writeback #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [DATA_W-1:0] result,
  output logic              issue_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [3:0]        out_flags,
  output logic              drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [3:0]        flags;   // {V,C,N,Z}
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d, occ;
  logic              s1_valid_q, s1_c_q, s1_sa_q, s1_sb_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic              drop_err_q;
  logic              accept, push, pop;
  logic              flag_z, flag_n, flag_v;
  entry_t            push_entry, head;

  // Slots are reserved at issue time: the in-flight S1 entry counts as
  // occupied so the push one cycle later can never find the FIFO full.
  // A same-cycle pop is deliberately ignored to keep this path short.
  assign occ         = count_q + CW'(s1_valid_q);
  assign issue_ready = occ < CW'(DEPTH);
  assign accept      = issue && issue_ready;

  assign push = s1_valid_q;
  assign pop  = out_valid && out_ready;

  // Flags from the registered difference plus the operand bits held in S1.
  assign flag_z = (result == '0);
  assign flag_n = result[DATA_W-1];
  assign flag_v = (s1_sa_q != s1_sb_q) && (result[DATA_W-1] != s1_sa_q);
  assign push_entry = '{data: result, tag: s1_tag_q,
                        flags: {flag_v, s1_c_q, flag_n, flag_z}};

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_data  = head.data;
  assign out_tag   = head.tag;
  assign out_flags = head.flags;
  assign drop_err  = drop_err_q;

  // Stage S1: remember tag, borrow and operand signs for a legal issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_c_q     <= 1'b0;
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_tag_q <= issue_tag;
        s1_c_q   <= (op1 < op2);
        s1_sa_q  <= op1[DATA_W-1];
        s1_sb_q  <= op2[DATA_W-1];
      end
    end
  end

  // Sticky flag for an issue that arrived while no slot was reserved.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    drop_err_q <= 1'b0;
    else if (issue && !issue_ready) drop_err_q <= 1'b1;
  end

  // Occupancy next state.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sub_writeback.sv
module tb_sub_writeback;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              issue = 1'b0;
  logic [TAG_W-1:0]  issue_tag = '0;
  logic [DATA_W-1:0] op1 = '0, op2 = '0, result = '0;
  logic              issue_ready, out_valid, drop_err;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic [3:0]        out_flags;

  sub_writeback #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .issue(issue), .issue_tag(issue_tag),
    .op1(op1), .op2(op2), .result(result), .issue_ready(issue_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_flags(out_flags), .drop_err(drop_err)
  );

  always #5 clock = ~clock;

  // Stand-in for the upstream subtracter: registered difference on enable.
  always @(posedge clock) if (issue) result <= op1 - op2;

  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of expected entries plus one pending issue.
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
    logic [3:0]  f;
  } ent_t;

  ent_t q[$];
  ent_t pend;
  bit   pend_v = 0;
  bit   m_drop = 0;
  int   npop = 0;

  function automatic ent_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tg);
    ent_t e;
    longint ua, ub, sd;
    logic [31:0] r;
    r  = a - b;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sd = longint'($signed(a)) - longint'($signed(b));
    e.d = r;
    e.t = tg;
    e.f[0] = (r == 32'd0);
    e.f[1] = r[31];
    e.f[2] = (ua - ub) < 0;
    e.f[3] = (sd != longint'($signed(r)));
    return e;
  endfunction

  function automatic bit mready();
    return (q.size() + int'(pend_v)) < DEPTH;
  endfunction

  task automatic model_reset();
    q.delete();
    pend_v = 0;
    m_drop = 0;
  endtask

  // One clock: drive at negedge, check against model, advance model, wait posedge.
  task automatic step(input logic iss, input logic [3:0] tg,
                      input logic [31:0] a, input logic [31:0] b, input logic rdy);
    bit r;
    @(negedge clock);
    issue = iss; issue_tag = tg; op1 = a; op2 = b; out_ready = rdy;
    #1;
    r = mready();
    chk("issue_ready", 64'(issue_ready), 64'(r));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("drop_err", 64'(drop_err), 64'(m_drop));
    if (q.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(q[0].d));
      chk("out_tag", 64'(out_tag), 64'(q[0].t));
      chk("out_flags", 64'(out_flags), 64'(q[0].f));
    end
    if (q.size() != 0 && rdy) begin
      void'(q.pop_front());
      npop++;
    end
    if (pend_v) q.push_back(pend);
    pend_v = iss && r;
    if (pend_v) pend = mk(a, b, tg);
    if (iss && !r) m_drop = 1;
    @(posedge clock);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, issued, guard;
    bit iss, rdy;

    vt[0] = '{32'd10, 32'd3, 32'd7, 4'b0000};
    vt[1] = '{32'd5, 32'd5, 32'd0, 4'b0001};
    vt[2] = '{32'd3, 32'd5, 32'hFFFF_FFFE, 4'b0110};
    vt[3] = '{32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b1000};
    vt[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1110};

    // Reset values.
    #12;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_tag", 64'(out_tag), 64'd0);
    chk("rst out_flags", 64'(out_flags), 64'd0);
    chk("rst drop_err", 64'(drop_err), 64'd0);
    chk("rst issue_ready", 64'(issue_ready), 64'd1);
    reset = 1'b1;
    model_reset();

    // Single issues: result and flags against hand constants, two edges after issue.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(i + 1), vt[i].a, vt[i].b, 1'b1);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      #2;
      chk("vec out_valid", 64'(out_valid), 64'd1);
      chk("vec out_data", 64'(out_data), 64'(vt[i].res));
      chk("vec out_flags", 64'(out_flags), 64'(vt[i].fl));
      chk("vec out_tag", 64'(out_tag), 64'(i + 1));
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
      step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    end

    // Backpressure: four accepted, fifth dropped, drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 4'(8 + i), 32'(100 * i), 32'd7, 1'b0);
    #2;
    chk("bp issue_ready low", 64'(issue_ready), 64'd0);
    step(1'b1, 4'd15, 32'd1, 32'd2, 1'b0);
    #2;
    chk("bp drop_err", 64'(drop_err), 64'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    #2;
    chk("bp drained", 64'(out_valid), 64'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i), $urandom, $urandom, 1'b0);
    for (int i = 0; i < 10; i++) step(mready(), 4'(4 + i), $urandom, $urandom, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);

    // Asynchronous reset between edges with three entries queued.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 2), $urandom, $urandom, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    #2;
    chk("pre-reset queued", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid rst out_valid", 64'(out_valid), 64'd0);
    chk("mid rst issue_ready", 64'(issue_ready), 64'd1);
    chk("mid rst drop_err", 64'(drop_err), 64'd0);
    chk("mid rst out_data", 64'(out_data), 64'd0);
    model_reset();
    #1;
    reset = 1'b1;
    step(1'b1, 4'd9, 32'd100, 32'd58, 1'b1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    #2;
    chk("post rst out_valid", 64'(out_valid), 64'd1);
    chk("post rst out_data", 64'(out_data), 64'd42);
    chk("post rst out_tag", 64'(out_tag), 64'd9);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    #2;
    chk("post rst popped", 64'(out_valid), 64'd0);

    // Pointer wrap: 20 legal issues with random consumer stalls.
    p0 = npop;
    issued = 0;
    guard = 0;
    while (issued < 20 && guard < 1000) begin
      iss = mready() && ($urandom_range(0, 3) != 0);
      rdy = $urandom_range(0, 1);
      step(iss, 4'(issued), $urandom, $urandom, rdy);
      if (iss) issued++;
      guard++;
    end
    chk("wrap issued", 64'(issued), 64'd20);
    for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    chk("wrap pops", 64'(npop - p0), 64'd20);
    chk("wrap drop_err", 64'(drop_err), 64'd0);
    chk("wrap empty", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/sub_writeback.md
Name: sub_writeback

Overview:
- Downstream stage of the subtracter. It tracks each issued subtract and samples the registered difference one cycle after issue.
- Derives the Z/N/C/V flags and queues {tag, result, flags} in a small FIFO.
- The FIFO drains to the register-file write port through a valid/ready handshake.
- Issue-side backpressure ensures the subtracter is only enabled when a FIFO slot is guaranteed.

Parameters:
- DATA_W, 32, operand/result width; must equal the width of the `DATA_WIDTH bus.
- TAG_W, 4, destination register tag width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  rising-edge clock shared with the subtracter.
- reset  in  1  asynchronous, active-low reset.
- issue  in  1  same pulse that drives the subtracter's enable.
- issue_tag  in  TAG_W  destination tag for this issue.
- op1  in  DATA_W  operand A, same net the subtracter sees.
- op2  in  DATA_W  operand B, same net the subtracter sees.
- result  in  DATA_W  subtracter output, valid the cycle after issue.
- issue_ready  out  1  a slot is reserved-free; issue is legal this cycle.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_W  head result.
- out_tag  out  TAG_W  head tag.
- out_flags  out  4  head flags {V,C,N,Z}.
- drop_err  out  1  sticky; set when issue occurs while issue_ready is 0.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, pointers 0, pipeline stage invalid. Outputs reset to out_valid=0, out_data=0, out_tag=0, out_flags=0, drop_err=0, issue_ready=1.
- Stage S1, captured on the clock edge where issue=1 and issue_ready=1:
  - s1_valid <= 1; s1_tag <= issue_tag.
  - s1_c <= (op1 < op2), unsigned compare, i.e. borrow.
  - s1_sa <= op1[MSB]; s1_sb <= op2[MSB].
  - Otherwise s1_valid <= 0.
- Stage S2, during the cycle s1_valid=1:
  - result holds op1-op2 from the issue cycle.
  - Z = (result==0); N = result[MSB]; C = s1_c.
  - V = (s1_sa != s1_sb) && (result[MSB] != s1_sa).
  - Entry {result, s1_tag, V,C,N,Z} is written into the FIFO on this edge.
- Latency: issue at edge k; entry written at edge k+1; out_valid=1 after edge k+1 when the FIFO was empty. Minimum issue-to-out_valid is 2 edges.
- Throughput: back-to-back issues are legal, one per cycle.
- FIFO operation:
  - Pop on the edge where out_valid && out_ready. out_* show the head combinationally from storage.
  - Push and pop in the same cycle are allowed at any occupancy, including full (a pop frees the slot).
  - Pointers wrap modulo DEPTH. The count register is DEPTH+1 states wide.
- issue_ready = (count + s1_valid) < DEPTH, with count the registered occupancy.
  - This is conservative: a same-cycle pop does not raise issue_ready.
  - No entry is ever lost once issued legally.
- Illegal issue (issue=1, issue_ready=0):
  - Not captured; S1 is not loaded.
  - drop_err <= 1 and stays 1 until reset.
  - The subtracter still computes, but its result is ignored.
- out_data and out_tag hold their value while out_valid=1 and out_ready=0.
- Reset mid-operation: the in-flight S1 entry and all FIFO entries are discarded; nothing is popped after reset releases.
- Once reset deasserts, the first edge may capture an issue.

Test Plan:
- Single issue, out_ready=1: op1=10, op2=3 -> 2 edges later out_valid=1, out_data=7, flags=0000; pops next edge, out_valid=0.
- Flag corners, one issue each:
  - 5-5 -> Z=1, flags 0001.
  - 3-5 -> 0xFFFFFFFE, C=1, N=1, flags 0110.
  - 0x80000000-1 -> 0x7FFFFFFF, V=1, C=0, flags 1000.
  - 0x7FFFFFFF-0xFFFFFFFF -> 0x80000000, V=1, C=1, N=1, flags 1110.
- Backpressure: out_ready=0, issue every cycle:
  - issue_ready falls after 4 accepted issues (count+s1_valid=4).
  - A 5th issue sets drop_err=1.
  - Raising out_ready drains tags in issue order; no extra entry appears.
- Full with simultaneous push/pop: FIFO holds 3 with S1 valid, out_ready=1 -> count stays 4→3 pattern correct; out_tag sequence is strictly in issue order with no duplicates.
- Pointer wrap: 20 issues with out_ready toggling at random -> 20 outputs in order, data matching the model, drop_err=0.
- Asynchronous reset asserted mid-stream, between clock edges, with 3 entries queued -> out_valid=0 immediately and issue_ready=1. The first issue after release emerges correctly 2 edges later.
